// File: rtl/icon_pkg.sv
// Shared definitions for the icon plotter and anything else that draws
// room/status icons: icon encodings, FSM states, screen geometry and bitmaps.
package icon_pkg;

  typedef enum logic [1:0] {
    ICON_LIGHT = 2'd0,
    ICON_DOOR  = 2'd1,
    ICON_SOLID = 2'd2,
    ICON_ERASE = 2'd3
  } icon_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int         SCREEN_W_DEF  = 160;
  localparam int         SCREEN_H_DEF  = 120;
  localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

  // Bitmaps are 8x8, packed row-major from the top-left pixel down to bit 0,
  // so pixel (row,col) lives at bit 63 - (row*8 + col).
  localparam int          BITMAP_W    = 8;
  localparam int          BITMAP_H    = 8;
  localparam logic [63:0] LIGHT_BITS  = 64'h18_3C_7E_7E_3C_18_18_3C;
  localparam logic [63:0] DOOR_BITS   = 64'h7E_42_42_42_46_42_42_7E;

  function automatic logic bitmapPixel(input logic [63:0] bits,
                                       input logic [2:0]  row,
                                       input logic [2:0]  col);
    logic [5:0] idx;
    idx = {row, col};
    return bits[~idx];
  endfunction

endpackage

// File: rtl/icon_rom.sv
// Combinational icon bitmap lookup: (icon, row, col) -> foreground bit.
// Pixels outside the 8x8 bitmap read as background except for the solid block.
module icon_rom
  import icon_pkg::*;
(
  input  logic [1:0] icon_sel_i,
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic       pixel_o
);

  logic inBitmap;

  assign inBitmap = (row_i < 4'(BITMAP_H)) && (col_i < 4'(BITMAP_W));

  always_comb begin
    pixel_o = 1'b0;
    case (icon_e'(icon_sel_i))
      ICON_LIGHT: pixel_o = inBitmap && bitmapPixel(LIGHT_BITS, row_i[2:0], col_i[2:0]);
      ICON_DOOR:  pixel_o = inBitmap && bitmapPixel(DOOR_BITS, row_i[2:0], col_i[2:0]);
      ICON_SOLID: pixel_o = 1'b1;
      ICON_ERASE: pixel_o = 1'b0;
      default:    pixel_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/icon_plotter.sv
// Walks an ICON_W x ICON_H window in raster order from a latched base point
// and emits one clipped, registered VGA pixel write per clock.
module icon_plotter
  import icon_pkg::*;
#(
  parameter int         ICON_W    = 8,
  parameter int         ICON_H    = 8,
  parameter int         SCREEN_W  = SCREEN_W_DEF,
  parameter int         SCREEN_H  = SCREEN_H_DEF,
  parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [1:0] icon_sel,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  localparam int CW = (ICON_W > 1) ? $clog2(ICON_W) : 1;
  localparam int RW = (ICON_H > 1) ? $clog2(ICON_H) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    baseX_q, baseX_d;
  logic [6:0]    baseY_q, baseY_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    colour_q, colour_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          plot_q, plot_d;
  logic [7:0]    vgaX_q, vgaX_d;
  logic [6:0]    vgaY_q, vgaY_d;
  logic [2:0]    vgaColour_q, vgaColour_d;

  logic [8:0] sumX;
  logic [7:0] sumY;
  logic       onScreen;
  logic       romPixel;
  logic       lastCol;
  logic       lastRow;

  // Sums are one bit wider than the screen coordinates so that icons hanging
  // off the right/bottom edge are clipped instead of wrapping to column/row 0.
  assign sumX     = {1'b0, baseX_q} + 9'(col_q);
  assign sumY     = {1'b0, baseY_q} + 8'(row_q);
  assign onScreen = (sumX < 9'(SCREEN_W)) && (sumY < 8'(SCREEN_H));
  assign lastCol  = (col_q == CW'(ICON_W - 1));
  assign lastRow  = (row_q == RW'(ICON_H - 1));

  icon_rom u_rom (
    .icon_sel_i (sel_q),
    .row_i      (4'(row_q)),
    .col_i      (4'(col_q)),
    .pixel_o    (romPixel)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    baseX_d     = baseX_q;
    baseY_d     = baseY_q;
    sel_d       = sel_q;
    colour_d    = colour_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    vgaX_d      = vgaX_q;
    vgaY_d      = vgaY_q;
    vgaColour_d = vgaColour_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          baseX_d  = base_x;
          baseY_d  = base_y;
          sel_d    = icon_sel;
          colour_d = colour_in;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_DRAW;
        end
      end

      ST_DRAW: begin
        busy_d      = 1'b1;
        plot_d      = onScreen;
        vgaX_d      = sumX[7:0];
        vgaY_d      = sumY[6:0];
        vgaColour_d = (sel_q != ICON_ERASE && romPixel) ? colour_q : BG_COLOUR;
        if (lastCol) begin
          col_d = '0;
          if (lastRow) begin
            state_d = ST_FINISH;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      // Output registers lag the state by one cycle, so done appears on the
      // edge that returns the FSM to IDLE.
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      baseX_q     <= '0;
      baseY_q     <= '0;
      sel_q       <= '0;
      colour_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      vgaX_q      <= '0;
      vgaY_q      <= '0;
      vgaColour_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      baseX_q     <= baseX_d;
      baseY_q     <= baseY_d;
      sel_q       <= sel_d;
      colour_q    <= colour_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      plot_q      <= plot_d;
      vgaX_q      <= vgaX_d;
      vgaY_q      <= vgaY_d;
      vgaColour_q <= vgaColour_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign vga_x      = vgaX_q;
  assign vga_y      = vgaY_q;
  assign vga_colour = vgaColour_q;

endmodule

// File: tb/tb_icon_plotter.sv
// Directed self-checking bench for icon_plotter: reset state, each icon type,
// edge clipping, ignored mid-draw start, reset mid-draw and held start.
module tb_icon_plotter;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [1:0] icon_sel;
  logic [2:0] colour_in;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  int checkCount = 0;
  int failCount  = 0;
  int plotted;

  logic [7:0] lightRows [8];
  logic [7:0] doorRows  [8];

  icon_plotter dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_x     (base_x),
    .base_y     (base_y),
    .icon_sel   (icon_sel),
    .colour_in  (colour_in),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] expColour(input logic [1:0] sel, input logic [2:0] c,
                                          input int r, input int k);
    logic [7:0] rowBits;
    case (sel)
      2'd0:    begin rowBits = lightRows[r]; return rowBits[7-k] ? c : 3'b000; end
      2'd1:    begin rowBits = doorRows[r];  return rowBits[7-k] ? c : 3'b000; end
      2'd2:    return c;
      default: return 3'b000;
    endcase
  endfunction

  // Starts a draw and checks every output cycle against the bench's own model.
  // intrudeAt >= 0 pulses start with different operands after that pixel.
  // keepStart leaves start high so the next draw chains directly.
  task automatic applyStimulus(input logic [7:0] bx, input logic [6:0] by,
                               input logic [1:0] sel, input logic [2:0] c,
                               input int intrudeAt, input bit keepStart,
                               output int nPlotted);
    int  ex, ey;
    bit  vis;
    nPlotted  = 0;
    base_x    = bx;
    base_y    = by;
    icon_sel  = sel;
    colour_in = c;
    start     = 1'b1;
    tick;
    checkOutput("busyAfterStart", 32'(busy), 1);
    checkOutput("plotAfterStart", 32'(plot), 0);
    checkOutput("doneAfterStart", 32'(done), 0);
    if (!keepStart) start = 1'b0;
    for (int p = 0; p < 64; p++) begin
      tick;
      ex  = int'(bx) + p % 8;
      ey  = int'(by) + p / 8;
      vis = (ex < 160) && (ey < 120);
      checkOutput($sformatf("plot[%0d]", p), 32'(plot), 32'(vis));
      if (vis) begin
        nPlotted++;
        checkOutput($sformatf("vgaX[%0d]", p), 32'(vga_x), 32'(ex));
        checkOutput($sformatf("vgaY[%0d]", p), 32'(vga_y), 32'(ey));
        checkOutput($sformatf("colour[%0d]", p), 32'(vga_colour),
                    32'(expColour(sel, c, p / 8, p % 8)));
      end
      checkOutput($sformatf("busyDraw[%0d]", p), 32'(busy), 1);
      checkOutput($sformatf("doneDraw[%0d]", p), 32'(done), 0);
      if (intrudeAt >= 0 && p == intrudeAt) begin
        start     = 1'b1;
        base_x    = bx + 8'd40;
        base_y    = 7'd3;
        icon_sel  = ~sel;
        colour_in = ~c;
      end else if (intrudeAt >= 0 && p == intrudeAt + 1) begin
        start = 1'b0;
      end
    end
    tick;
    checkOutput("doneFinish", 32'(done), 1);
    checkOutput("busyFinish", 32'(busy), 0);
    checkOutput("plotFinish", 32'(plot), 0);
    if (!keepStart) begin
      tick;
      checkOutput("doneAfter", 32'(done), 0);
      checkOutput("busyAfter", 32'(busy), 0);
      checkOutput("plotAfter", 32'(plot), 0);
    end
  endtask

  initial begin
    lightRows[0] = 8'h18; lightRows[1] = 8'h3C; lightRows[2] = 8'h7E; lightRows[3] = 8'h7E;
    lightRows[4] = 8'h3C; lightRows[5] = 8'h18; lightRows[6] = 8'h18; lightRows[7] = 8'h3C;
    doorRows[0]  = 8'h7E; doorRows[1]  = 8'h42; doorRows[2]  = 8'h42; doorRows[3]  = 8'h42;
    doorRows[4]  = 8'h46; doorRows[5]  = 8'h42; doorRows[6]  = 8'h42; doorRows[7]  = 8'h7E;

    reset     = 1'b1;
    start     = 1'b0;
    base_x    = '0;
    base_y    = '0;
    icon_sel  = '0;
    colour_in = '0;
    tick;
    tick;
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetPlot", 32'(plot), 0);
    checkOutput("resetX", 32'(vga_x), 0);
    checkOutput("resetY", 32'(vga_y), 0);
    checkOutput("resetColour", 32'(vga_colour), 0);
    reset = 1'b0;
    tick;
    checkOutput("idleBusy", 32'(busy), 0);

    applyStimulus(8'd60, 7'd73, 2'd0, 3'b110, -1, 1'b0, plotted);
    checkOutput("lightPlotted", 32'(plotted), 64);

    applyStimulus(8'd10, 7'd10, 2'd3, 3'b111, -1, 1'b0, plotted);
    checkOutput("erasePlotted", 32'(plotted), 64);

    applyStimulus(8'd156, 7'd116, 2'd2, 3'b101, -1, 1'b0, plotted);
    checkOutput("clipCornerPlotted", 32'(plotted), 16);

    applyStimulus(8'd250, 7'd126, 2'd2, 3'b101, -1, 1'b0, plotted);
    checkOutput("noWrapPlotted", 32'(plotted), 0);

    applyStimulus(8'd30, 7'd40, 2'd1, 3'b011, 20, 1'b0, plotted);
    checkOutput("doorIntrudePlotted", 32'(plotted), 64);

    base_x    = 8'd50;
    base_y    = 7'd50;
    icon_sel  = 2'd2;
    colour_in = 3'b010;
    start     = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    checkOutput("midDrawPlot", 32'(plot), 1);
    reset = 1'b1;
    tick;
    checkOutput("midResetPlot", 32'(plot), 0);
    checkOutput("midResetBusy", 32'(busy), 0);
    checkOutput("midResetDone", 32'(done), 0);
    checkOutput("midResetX", 32'(vga_x), 0);
    start = 1'b1;
    tick;
    checkOutput("resetWinsBusy", 32'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    tick;
    checkOutput("resetWinsIdle", 32'(busy), 0);
    checkOutput("resetWinsPlot", 32'(plot), 0);

    applyStimulus(8'd0, 7'd0, 2'd1, 3'b010, -1, 1'b0, plotted);
    checkOutput("freshPlotted", 32'(plotted), 64);

    applyStimulus(8'd20, 7'd20, 2'd0, 3'b100, -1, 1'b1, plotted);
    checkOutput("holdFirstPlotted", 32'(plotted), 64);
    applyStimulus(8'd20, 7'd20, 2'd0, 3'b100, -1, 1'b0, plotted);
    checkOutput("holdSecondPlotted", 32'(plotted), 64);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
